// File: rtl/watchdog_pkg.sv
// Shared types and Q-format constants for the watchdog ratio datapath.
package watchdog_pkg;

  localparam int RATIO_W = 32;
  localparam int RATIO_F = 16;

  localparam logic [RATIO_W-1:0] QF_ONE = {{(RATIO_W-RATIO_F-1){1'b0}}, 1'b1, {RATIO_F{1'b0}}};
  localparam logic [RATIO_W-1:0] QF_MAX = {1'b0, {(RATIO_W-1){1'b1}}};
  localparam logic [RATIO_W-1:0] QF_MIN = {1'b1, {(RATIO_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_MUL,
    S_OUT
  } ratio_st_t;

endpackage

// File: rtl/qmul_sat.sv
// Combinational signed x unsigned QF multiply, arithmetic shift by F, saturate to W bits.
module qmul_sat
  import watchdog_pkg::*;
#(
  parameter int W = RATIO_W,
  parameter int F = RATIO_F
) (
  input  logic [W-1:0] num,
  input  logic [W-1:0] y,
  output logic [W-1:0] product,
  output logic         sat
);

  localparam logic signed [2*W:0] MAX_EXT = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MIN_EXT = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  logic [2*W:0]        num_ext;
  logic [2*W:0]        y_ext;
  logic signed [2*W:0] prod;
  logic signed [2*W:0] shifted;

  // Both operands widened to 2W+1 so the truncated product is exact.
  assign num_ext = {{(W+1){num[W-1]}}, num};
  assign y_ext   = {{(W+1){1'b0}}, y};
  assign prod    = $signed(num_ext * y_ext);
  assign shifted = prod >>> F;

  always_comb begin
    product = shifted[W-1:0];
    sat     = 1'b0;
    if (shifted > MAX_EXT) begin
      product = {1'b0, {(W-1){1'b1}}};
      sat     = 1'b1;
    end else if (shifted < MIN_EXT) begin
      product = {1'b1, {(W-1){1'b0}}};
      sat     = 1'b1;
    end
  end

endmodule

// File: rtl/ratio_ctrl.sv
// Ratio unit: num / den via the shared reciprocal unit, bounded wait, saturating multiply.
module ratio_ctrl
  import watchdog_pkg::*;
#(
  parameter int W   = RATIO_W,
  parameter int F   = RATIO_F,
  parameter int TMO = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_den,
  output logic         recip_start,
  output logic [W-1:0] recip_x,
  input  logic         recip_done,
  input  logic [W-1:0] recip_y,
  input  logic         recip_invalid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err_div,
  output logic         out_err_tmo,
  output logic         out_sat
);

  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  ratio_st_t     state_reg;
  logic [W-1:0]  num_reg;
  logic [W-1:0]  den_reg;
  logic [W-1:0]  y_reg;
  logic [CW-1:0] cnt_reg;
  logic          err_div_reg;
  logic          err_tmo_reg;
  logic          sat_reg;
  logic [W-1:0]  data_reg;

  logic [W-1:0]  mul_product;
  logic          mul_sat;

  qmul_sat #(
    .W (W),
    .F (F)
  ) u_qmul (
    .num     (num_reg),
    .y       (y_reg),
    .product (mul_product),
    .sat     (mul_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      num_reg     <= '0;
      den_reg     <= '0;
      y_reg       <= '0;
      cnt_reg     <= '0;
      err_div_reg <= 1'b0;
      err_tmo_reg <= 1'b0;
      sat_reg     <= 1'b0;
      data_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            num_reg     <= in_num;
            den_reg     <= in_den;
            err_div_reg <= 1'b0;
            err_tmo_reg <= 1'b0;
            sat_reg     <= 1'b0;
            state_reg   <= S_REQ;
          end
        end
        S_REQ: begin
          cnt_reg   <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          // A response landing on the last wait cycle still counts.
          if (recip_done) begin
            y_reg       <= recip_y;
            err_div_reg <= recip_invalid;
            state_reg   <= S_MUL;
          end else if (cnt_reg == CNT_LAST) begin
            y_reg       <= '0;
            err_tmo_reg <= 1'b1;
            state_reg   <= S_MUL;
          end
        end
        S_MUL: begin
          if (err_div_reg || err_tmo_reg) begin
            data_reg <= '0;
            sat_reg  <= 1'b0;
          end else begin
            data_reg <= mul_product;
            sat_reg  <= mul_sat;
          end
          state_reg <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_reg == S_IDLE);
  assign recip_start = (state_reg == S_REQ);
  assign out_valid   = (state_reg == S_OUT);
  assign recip_x     = den_reg;
  assign out_data    = data_reg;
  assign out_err_div = err_div_reg;
  assign out_err_tmo = err_tmo_reg;
  assign out_sat     = sat_reg;

endmodule

// File: doc/ratio_ctrl.md
# ratio_ctrl

Fixed-point ratio unit: accepts a signed Q(W-F).F numerator/denominator pair over a valid/ready request port and acts as the initiator of the reciprocal unit's start_calc/done protocol. It drives the denominator, waits for the reciprocal, then multiplies numerator × reciprocal with saturation. A bounded wait with timeout keeps a hung reciprocal unit from stalling the watchdog datapath. Sits between the watchdog rate/threshold logic and the shared reciprocal unit.

## Interface
- W, 32, data width in bits
- F, 16, fractional bits (Q format shared with the reciprocal unit)
- TMO, 64, maximum cycles spent waiting for recip_done; must be ≥ 2

- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_num  in  W  signed QF numerator
- in_den  in  W  signed QF denominator
- recip_start  out  1  one-cycle start pulse to the reciprocal unit
- recip_x  out  W  operand to the reciprocal unit; held stable from the start cycle through the done cycle
- recip_done  in  1  reciprocal result valid (one cycle)
- recip_y  in  W  unsigned QF reciprocal
- recip_invalid  in  1  qualified by recip_done; operand was ≤ 0
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  W  signed QF ratio
- out_err_div  out  1  denominator ≤ 0
- out_err_tmo  out  1  reciprocal timed out
- out_sat  out  1  result saturated

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_MUL, S_OUT.
- S_IDLE: in_ready=1. On handshake, latch num/den and clear the flags. Go to S_REQ.
- S_REQ: recip_start=1 for exactly this cycle. Clear the wait counter. Go to S_WAIT.
- S_WAIT: recip_start=0 and the counter increments.
  - On recip_done: capture recip_y and recip_invalid, then go to S_MUL.
  - Else, when the counter reaches TMO-1: set err_tmo, force the captured y to 0, go to S_MUL.
  - recip_done and the timeout in the same cycle: done wins.
- S_MUL: if err_div or err_tmo is set, the result is 0 and sat=0. Otherwise:
  - Compute the product of signed num and zero-extended y, at width 2W+1.
  - Arithmetic-shift the product right by F.
  - Saturate to [-2^(W-1), 2^(W-1)-1] and set sat if clipped.
  - Register the result, then go to S_OUT.
- S_OUT: out_valid=1. out_data and the flags stay stable until out_ready. On handshake go to S_IDLE.
- recip_x = latched den in all states; it changes only on request acceptance.
- recip_done outside S_WAIT (for example a late response after a timeout) is ignored.
- Reset, including mid-operation, forces S_IDLE immediately. All registers return to their reset values.

## Timing
- Reset values: in_ready=1, recip_start=0, recip_x=0, out_valid=0, out_data=0, all flags 0.
- Acceptance at edge 0 → recip_start high in cycle 1.
- recip_done seen in cycle k → out_valid in cycle k+2.
- With the team reciprocal unit (done 9 cycles after the start is sampled), out_valid arrives 12 cycles after acceptance for a positive den. For den ≤ 0 it arrives 5 cycles after acceptance.
- Timeout: out_valid arrives TMO+3 cycles after acceptance.
- Throughput: one request in flight. in_ready=0 from acceptance until the cycle after the output handshake.
- No combinational path from any input to any output except in_ready and out_valid, which are decoded from state only.

## Structure
- watchdog_pkg holds:
  - the state enum ratio_st_t
  - the shared W/F defaults
  - the QF constants QF_ONE and QF_MAX/QF_MIN saturation bounds
- One sub-module: qmul_sat, a combinational signed×unsigned QF multiply with arithmetic shift and saturation. Its outputs are product and sat. It is instantiated in the S_MUL datapath.
- Bench uses a behavioural reciprocal responder with programmable latency and result, plus the real reciprocal unit for one integration run.

## Test plan
- num=196608 (3.0), den=131072 (2.0), responder returns y=32768 after 9 cycles → out_data=98304 (1.5), flags 0, out_valid 12 cycles after acceptance.
- den=0, responder returns done with invalid=1 → out_data=0, out_err_div=1. recip_x=0 held through done.
- num=0x7FFF0000, y=262144 (4.0) → out_data=0x7FFFFFFF, out_sat=1. num=0x80000000, y=131072 → out_data=0x80000000, out_sat=1.
- Responder never answers, TMO=64 → out_valid at cycle 67 with out_err_tmo=1 and out_data=0. A late recip_done in S_IDLE is ignored and the next request completes normally.
- out_ready held low for 5 cycles in S_OUT → out_data and flags stable, in_ready=0, and in_valid is ignored. Handshake → in_ready=1 the next cycle.
- rst_n pulsed low in S_WAIT → recip_start=0 and out_valid=0 immediately, in_ready=1. A new request afterwards produces the correct result.
